// File: rtl/qoi_decoder.sv
// Streaming QOI chunk decoder: consumes raw chunk bytes and emits RGBA pixels
// through a valid/ready output until the programmed pixel count is reached.
module qoi_decoder #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] pixel_count,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [31:0]      out_pixel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        StIdle,
        StOp,
        StArg,
        StEmit,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      prev_q, prev_d;
    logic [31:0]      out_pixel_q, out_pixel_d;
    logic [7:0]       op_q, op_d;
    logic [23:0]      arg_sr_q, arg_sr_d;
    logic [1:0]       arg_cnt_q, arg_cnt_d;
    logic [6:0]       run_left_q, run_left_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [63:0]      idx_valid_q, idx_valid_d;
    logic [31:0]      index_q [64];

    logic             in_fire;
    logic             out_fire;
    logic [CNT_W-1:0] cnt_inc;
    logic             cnt_last;
    logic             op_is_tag8;
    logic             op_needs_args;
    logic             op_is_run;
    logic [1:0]       arg_last_cnt;
    logic             arg_last;
    logic [7:0]       pr, pg, pb, pa;
    logic [7:0]       luma_dg;
    logic [31:0]      new_pixel;
    logic [7:0]       hash_sum;
    logic [5:0]       new_hash;
    logic             idx_we;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign cnt_last = (cnt_inc == count_q);

    // Opcode classification of the byte currently on in_data (used in StOp).
    assign op_is_tag8    = (in_data == 8'hFE) || (in_data == 8'hFF);
    assign op_needs_args = op_is_tag8 || (in_data[7:6] == 2'b10);
    assign op_is_run     = !op_is_tag8 && (in_data[7:6] == 2'b11);

    // Argument index of the final byte for the latched opcode.
    assign arg_last_cnt = (op_q == 8'hFE) ? 2'd2 : (op_q == 8'hFF) ? 2'd3 : 2'd0;
    assign arg_last     = (arg_cnt_q == arg_last_cnt);

    assign pr      = prev_q[31:24];
    assign pg      = prev_q[23:16];
    assign pb      = prev_q[15:8];
    assign pa      = prev_q[7:0];
    assign luma_dg = {2'b00, op_q[5:0]} - 8'd32;

    // Candidate pixel for the chunk completing on this byte.
    always_comb begin
        new_pixel = prev_q;
        if (state_q == StOp) begin
            if (in_data[7:6] == 2'b00) begin
                new_pixel = idx_valid_q[in_data[5:0]] ? index_q[in_data[5:0]] : 32'h0;
            end else if (in_data[7:6] == 2'b01) begin
                new_pixel = {pr + {6'b0, in_data[5:4]} - 8'd2,
                             pg + {6'b0, in_data[3:2]} - 8'd2,
                             pb + {6'b0, in_data[1:0]} - 8'd2,
                             pa};
            end
        end else begin
            if (op_q == 8'hFE) begin
                new_pixel = {arg_sr_q[15:8], arg_sr_q[7:0], in_data, pa};
            end else if (op_q == 8'hFF) begin
                new_pixel = {arg_sr_q[23:16], arg_sr_q[15:8], arg_sr_q[7:0], in_data};
            end else begin
                new_pixel = {pr + luma_dg + {4'b0, in_data[7:4]} - 8'd8,
                             pg + luma_dg,
                             pb + luma_dg + {4'b0, in_data[3:0]} - 8'd8,
                             pa};
            end
        end
    end

    // Index slot of the candidate pixel; only the low 6 bits of the sum matter.
    assign hash_sum = new_pixel[31:24] * 8'd3 + new_pixel[23:16] * 8'd5
                    + new_pixel[15:8] * 8'd7 + new_pixel[7:0] * 8'd11;
    assign new_hash = hash_sum[5:0];

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start overrides any pending handshake.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = (pixel_count == '0) ? StDone : StOp;
        end else begin
            case (state_q)
                StOp: begin
                    if (in_fire) begin
                        if (op_needs_args) begin
                            state_d = StArg;
                        end else if (op_is_run) begin
                            state_d = StRun;
                        end else begin
                            state_d = StEmit;
                        end
                    end
                end
                StArg: begin
                    if (in_fire && arg_last) begin
                        state_d = StEmit;
                    end
                end
                StEmit: begin
                    if (out_fire) begin
                        state_d = cnt_last ? StDone : StOp;
                    end
                end
                StRun: begin
                    if (out_fire) begin
                        if (cnt_last) begin
                            state_d = StDone;
                        end else if (run_left_q == 7'd1) begin
                            state_d = StOp;
                        end
                    end
                end
                StIdle, StDone: state_d = state_q;
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        in_ready  = (state_q == StOp) || (state_q == StArg);
        out_valid = (state_q == StEmit) || (state_q == StRun);
        busy      = (state_q == StOp) || (state_q == StArg) ||
                    (state_q == StEmit) || (state_q == StRun);
        done      = (state_q == StDone);
        out_pixel = out_pixel_q;
    end

    // Datapath next-state: argument capture, pixel/index update, counters.
    always_comb begin
        prev_d      = prev_q;
        out_pixel_d = out_pixel_q;
        op_d        = op_q;
        arg_sr_d    = arg_sr_q;
        arg_cnt_d   = arg_cnt_q;
        run_left_d  = run_left_q;
        cnt_d       = cnt_q;
        count_d     = count_q;
        idx_valid_d = idx_valid_q;
        idx_we      = 1'b0;
        if (start) begin
            prev_d      = 32'h000000FF;
            idx_valid_d = '0;
            cnt_d       = '0;
            count_d     = pixel_count;
        end else begin
            case (state_q)
                StOp: begin
                    if (in_fire) begin
                        op_d      = in_data;
                        arg_cnt_d = 2'd0;
                        if (op_is_run) begin
                            run_left_d  = {1'b0, in_data[5:0]} + 7'd1;
                            out_pixel_d = prev_q;
                        end else if (!op_needs_args) begin
                            prev_d                = new_pixel;
                            out_pixel_d           = new_pixel;
                            idx_valid_d[new_hash] = 1'b1;
                            idx_we                = 1'b1;
                        end
                    end
                end
                StArg: begin
                    if (in_fire) begin
                        arg_sr_d  = {arg_sr_q[15:0], in_data};
                        arg_cnt_d = arg_cnt_q + 2'd1;
                        if (arg_last) begin
                            prev_d                = new_pixel;
                            out_pixel_d           = new_pixel;
                            idx_valid_d[new_hash] = 1'b1;
                            idx_we                = 1'b1;
                        end
                    end
                end
                StEmit: begin
                    if (out_fire) begin
                        cnt_d = cnt_inc;
                    end
                end
                StRun: begin
                    if (out_fire) begin
                        cnt_d      = cnt_inc;
                        run_left_d = run_left_q - 7'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q      <= 32'h000000FF;
            out_pixel_q <= 32'h0;
            op_q        <= 8'h0;
            arg_sr_q    <= 24'h0;
            arg_cnt_q   <= 2'd0;
            run_left_q  <= 7'd0;
            cnt_q       <= '0;
            count_q     <= '0;
            idx_valid_q <= '0;
        end else begin
            prev_q      <= prev_d;
            out_pixel_q <= out_pixel_d;
            op_q        <= op_d;
            arg_sr_q    <= arg_sr_d;
            arg_cnt_q   <= arg_cnt_d;
            run_left_q  <= run_left_d;
            cnt_q       <= cnt_d;
            count_q     <= count_d;
            idx_valid_q <= idx_valid_d;
        end
    end

    // Index storage; contents are qualified by idx_valid_q so no reset is needed.
    always_ff @(posedge clk) begin
        if (idx_we) begin
            index_q[new_hash] <= new_pixel;
        end
    end

endmodule

// File: tb/tb_qoi_decoder.sv
// Self-checking bench for qoi_decoder: directed chunk streams plus randomized
// streams checked against a behavioural QOI decode model.
module tb_qoi_decoder;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] pixel_count;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_pixel;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    qoi_decoder #(.CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pixel_count (pixel_count),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_pixel   (out_pixel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  stim_q[$];
    logic [31:0] obs_q[$];
    logic [31:0] exp_q[$];
    int          consumed;
    int          exp_used;
    int          stall_bad;
    bit          timed_out;

    // Drive stim_q into the decoder and collect every handshaken pixel.
    // rmode: 0 ready high, 1 ready toggling 1010..., 2 random. vmode 1 adds input gaps.
    task automatic run_image(input int cnt, input bit do_start, input int rmode, input int vmode);
        int bi = 0;
        int post = 0;
        bit held = 0;
        logic [31:0] held_pix = '0;
        obs_q.delete();
        stall_bad = 0;
        timed_out = 1;
        if (do_start) begin
            @(negedge clk);
            start = 1; pixel_count = cnt[15:0]; in_valid = 0; out_ready = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            start    = 0;
            in_valid = (bi < stim_q.size()) && (vmode == 0 || $urandom_range(0, 2) != 0);
            in_data  = (bi < stim_q.size()) ? stim_q[bi] : 8'h00;
            case (rmode)
                0:       out_ready = 1;
                1:       out_ready = (cyc % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (in_valid && in_ready) bi++;
            if (out_valid && held && out_pixel !== held_pix) stall_bad++;
            if (out_valid && out_ready) begin
                obs_q.push_back(out_pixel);
                held = 0;
            end else if (out_valid) begin
                held = 1;
                held_pix = out_pixel;
            end else begin
                held = 0;
            end
            if (done) begin
                post++;
                if (post > 4) begin
                    timed_out = 0;
                    break;
                end
            end
        end
        consumed = bi;
        in_valid = 0;
        out_ready = 0;
    endtask

    // Reference decode of stim_q from the format rules; fills exp_q and exp_used.
    task automatic model_decode(input int cnt);
        logic [31:0] idx [64];
        logic [31:0] prev;
        logic [7:0]  b, b1, r, g, bl, a;
        int i = 0;
        int n = 0;
        int dg, h;
        for (int k = 0; k < 64; k++) idx[k] = 32'h0;
        prev = 32'h000000FF;
        exp_q.delete();
        while (n < cnt && i < stim_q.size()) begin
            b = stim_q[i];
            i++;
            {r, g, bl, a} = prev;
            if (b == 8'hFE) begin
                r = stim_q[i]; g = stim_q[i+1]; bl = stim_q[i+2]; i += 3;
            end else if (b == 8'hFF) begin
                r = stim_q[i]; g = stim_q[i+1]; bl = stim_q[i+2]; a = stim_q[i+3]; i += 4;
            end else if (b[7:6] == 2'b00) begin
                {r, g, bl, a} = idx[b[5:0]];
            end else if (b[7:6] == 2'b01) begin
                r  = 8'(int'(r)  + int'(b[5:4]) - 2);
                g  = 8'(int'(g)  + int'(b[3:2]) - 2);
                bl = 8'(int'(bl) + int'(b[1:0]) - 2);
            end else if (b[7:6] == 2'b10) begin
                dg = int'(b[5:0]) - 32;
                b1 = stim_q[i];
                i++;
                r  = 8'(int'(r)  + dg + int'(b1[7:4]) - 8);
                g  = 8'(int'(g)  + dg);
                bl = 8'(int'(bl) + dg + int'(b1[3:0]) - 8);
            end else begin
                for (int k = 0; k <= int'(b[5:0]); k++) begin
                    if (n < cnt) begin
                        exp_q.push_back(prev);
                        n++;
                    end
                end
                continue;
            end
            prev = {r, g, bl, a};
            exp_q.push_back(prev);
            n++;
            h = (3 * int'(r) + 5 * int'(g) + 7 * int'(bl) + 11 * int'(a)) % 64;
            idx[h] = prev;
        end
        exp_used = i;
    endtask

    // Random chunk stream producing at least cnt pixels, plus one trailing byte.
    task automatic gen_stream(input int cnt);
        int px = 0;
        int op;
        logic [7:0] rb;
        stim_q.delete();
        while (px < cnt) begin
            op = $urandom_range(0, 5);
            case (op)
                0: begin
                    stim_q.push_back(8'hFE);
                    repeat (3) begin rb = 8'($urandom); stim_q.push_back(rb); end
                    px++;
                end
                1: begin
                    stim_q.push_back(8'hFF);
                    repeat (4) begin rb = 8'($urandom); stim_q.push_back(rb); end
                    px++;
                end
                2: begin stim_q.push_back(8'($urandom_range(0, 63))); px++; end
                3: begin stim_q.push_back(8'h40 | 8'($urandom_range(0, 63))); px++; end
                4: begin
                    stim_q.push_back(8'h80 | 8'($urandom_range(0, 63)));
                    rb = 8'($urandom);
                    stim_q.push_back(rb);
                    px++;
                end
                default: begin
                    rb = 8'($urandom_range(0, 61));
                    stim_q.push_back(8'hC0 | rb);
                    px += int'(rb) + 1;
                end
            endcase
        end
        rb = 8'($urandom);
        stim_q.push_back(rb);
    endtask

    task automatic test_reset;
        rst = 0; start = 0; pixel_count = 0; in_data = 0; in_valid = 0; out_ready = 0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_pixel !== 32'h0) begin n_err++; $display("FAIL reset_out_pixel: got %h want 0", out_pixel); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        rst = 1;
        @(negedge clk);
        #1;
        n_cmp++; if (in_ready !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL idle_after_reset: in_ready=%b busy=%b want 0 0", in_ready, busy);
        end
    endtask

    task automatic test_rgb;
        stim_q = '{8'hFE, 8'h10, 8'h20, 8'h30};
        run_image(1, 1, 0, 0);
        n_cmp++; if (timed_out) begin n_err++; $display("FAIL rgb_timeout: done never seen"); end
        n_cmp++; if (obs_q.size() != 1 || obs_q[0] !== 32'h102030FF) begin
            n_err++; $display("FAIL rgb_pixel: got %0d pixels first %h want 1 pixel 102030ff",
                              obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 32'h0);
        end
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL rgb_status: done=%b busy=%b want 1 0", done, busy);
        end
        // Slot 21 must hold the pixel just produced.
        stim_q = '{8'hFE, 8'h10, 8'h20, 8'h30, 8'h15};
        exp_q = '{32'h102030FF, 32'h102030FF};
        run_image(2, 1, 0, 0);
        n_cmp++; if (obs_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL rgb_index_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[k]) begin
            n_cmp++; if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) begin
                n_err++; $display("FAIL rgb_index_px%0d: got %h want %h", k,
                                  k < obs_q.size() ? obs_q[k] : 32'h0, exp_q[k]);
            end
        end
    endtask

    task automatic test_diff;
        stim_q = '{8'hFE, 8'h10, 8'h20, 8'h30, 8'h7F};
        exp_q = '{32'h102030FF, 32'h112131FF};
        run_image(2, 1, 0, 0);
        n_cmp++; if (obs_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL diff_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[k]) begin
            n_cmp++; if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) begin
                n_err++; $display("FAIL diff_px%0d: got %h want %h", k,
                                  k < obs_q.size() ? obs_q[k] : 32'h0, exp_q[k]);
            end
        end
        stim_q = '{8'h40};
        run_image(1, 1, 0, 0);
        n_cmp++; if (obs_q.size() != 1 || obs_q[0] !== 32'hFEFEFEFF) begin
            n_err++; $display("FAIL diff_wrap: got %0d pixels first %h want fefefeff",
                              obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 32'h0);
        end
    endtask

    task automatic test_luma;
        stim_q = '{8'hA5, 8'h9A};
        run_image(1, 1, 2, 1);
        n_cmp++; if (obs_q.size() != 1 || obs_q[0] !== 32'h060507FF) begin
            n_err++; $display("FAIL luma_pixel: got %0d pixels first %h want 060507ff",
                              obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 32'h0);
        end
        n_cmp++; if (consumed != 2) begin n_err++; $display("FAIL luma_consumed: got %0d want 2", consumed); end
    endtask

    task automatic test_rgba_index;
        stim_q = '{8'hFF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0E, 8'h05};
        exp_q = '{32'h01020304, 32'h01020304, 32'h00000000};
        run_image(3, 1, 0, 0);
        n_cmp++; if (obs_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL rgba_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[k]) begin
            n_cmp++; if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) begin
                n_err++; $display("FAIL rgba_px%0d: got %h want %h", k,
                                  k < obs_q.size() ? obs_q[k] : 32'h0, exp_q[k]);
            end
        end
    endtask

    task automatic test_run_stall;
        stim_q = '{8'hC3};
        run_image(4, 1, 1, 0);
        n_cmp++; if (obs_q.size() != 4) begin n_err++; $display("FAIL run_count: got %0d want 4", obs_q.size()); end
        foreach (obs_q[k]) begin
            n_cmp++; if (obs_q[k] !== 32'h000000FF) begin
                n_err++; $display("FAIL run_px%0d: got %h want 000000ff", k, obs_q[k]);
            end
        end
        n_cmp++; if (stall_bad != 0) begin n_err++; $display("FAIL run_stable: got %0d changes want 0", stall_bad); end
        n_cmp++; if (consumed != 1) begin n_err++; $display("FAIL run_consumed: got %0d want 1", consumed); end
    endtask

    task automatic test_run_trunc;
        stim_q = '{8'hC9, 8'h00};
        run_image(3, 1, 0, 0);
        n_cmp++; if (obs_q.size() != 3) begin n_err++; $display("FAIL trunc_count: got %0d want 3", obs_q.size()); end
        n_cmp++; if (consumed != 1) begin n_err++; $display("FAIL trunc_consumed: got %0d want 1", consumed); end
        n_cmp++; if (done !== 1'b1 || in_ready !== 1'b0) begin
            n_err++; $display("FAIL trunc_done: done=%b in_ready=%b want 1 0", done, in_ready);
        end
    endtask

    task automatic test_reset_midrun;
        @(negedge clk);
        start = 1; pixel_count = 16'd3; in_valid = 0; out_ready = 0;
        @(negedge clk);
        start = 0; in_valid = 1; in_data = 8'hC9;
        @(negedge clk);
        in_valid = 0;
        #1;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL midrun_active: out_valid=%b want 1", out_valid); end
        @(negedge clk);
        rst = 0;
        #1;
        n_cmp++; if ({in_ready, out_valid, busy, done} !== 4'b0 || out_pixel !== 32'h0) begin
            n_err++; $display("FAIL midrun_reset: rdy=%b vld=%b busy=%b done=%b px=%h want all 0",
                              in_ready, out_valid, busy, done, out_pixel);
        end
        @(negedge clk);
        rst = 1;
    endtask

    task automatic test_count_zero;
        @(negedge clk);
        start = 1; pixel_count = 16'd0;
        @(negedge clk);
        start = 0; in_valid = 1; in_data = 8'hFE;
        #1;
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL zero_count: done=%b busy=%b rdy=%b vld=%b want 1 0 0 0",
                              done, busy, in_ready, out_valid);
        end
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic test_start_during_handshake;
        int bi = 0;
        stim_q = '{8'hFE, 8'h10, 8'h20, 8'h30};
        @(negedge clk);
        start = 1; pixel_count = 16'd2; in_valid = 0; out_ready = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            start = 0;
            if (bi >= 4) break;
            in_valid = 1; in_data = stim_q[bi];
            #1;
            if (in_ready) bi++;
        end
        in_valid = 0;
        #1;
        n_cmp++; if (out_valid !== 1'b1 || out_pixel !== 32'h102030FF) begin
            n_err++; $display("FAIL sh_pixel: vld=%b px=%h want 1 102030ff", out_valid, out_pixel);
        end
        @(negedge clk);
        start = 1; pixel_count = 16'd1; out_ready = 1;
        @(negedge clk);
        start = 0; out_ready = 0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
            n_err++; $display("FAIL sh_restart: vld=%b busy=%b done=%b want 0 1 0", out_valid, busy, done);
        end
        stim_q = '{8'h40};
        run_image(1, 0, 0, 0);
        n_cmp++; if (timed_out || obs_q.size() != 1 || obs_q[0] !== 32'hFEFEFEFF) begin
            n_err++; $display("FAIL sh_after: timeout=%b pixels=%0d first %h want 0 1 fefefeff",
                              timed_out, obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 32'h0);
        end
    endtask

    task automatic test_random;
        int cnt;
        for (int img = 0; img < 20; img++) begin
            cnt = $urandom_range(1, 24);
            gen_stream(cnt);
            model_decode(cnt);
            run_image(cnt, 1, $urandom_range(0, 2), $urandom_range(0, 1));
            n_cmp++; if (timed_out || obs_q.size() != exp_q.size()) begin
                n_err++; $display("FAIL rand%0d_count: timeout=%b got %0d want %0d",
                                  img, timed_out, obs_q.size(), exp_q.size());
            end
            foreach (exp_q[k]) begin
                n_cmp++; if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) begin
                    n_err++; $display("FAIL rand%0d_px%0d: got %h want %h", img, k,
                                      k < obs_q.size() ? obs_q[k] : 32'h0, exp_q[k]);
                end
            end
            n_cmp++; if (consumed != exp_used) begin
                n_err++; $display("FAIL rand%0d_consumed: got %0d want %0d", img, consumed, exp_used);
            end
            n_cmp++; if (stall_bad != 0) begin
                n_err++; $display("FAIL rand%0d_stable: got %0d changes want 0", img, stall_bad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rgb();
        test_diff();
        test_luma();
        test_rgba_index();
        test_run_stall();
        test_run_trunc();
        test_reset_midrun();
        test_count_zero();
        test_start_during_handshake();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
